// File: rtl/hs32_gpio_pkg.sv
// hs32_gpio_pkg
//   Shared constants and helpers for the hs32_wb_gpio Wishbone GPIO bank.
//   - GPIO_SYNC_STAGES : depth of the pad-input synchroniser
//   - GPIO_OFF_*       : register word offsets, compared against adr[7:2]
//   - gpio_byte_mask   : expands Wishbone byte selects into a 32-bit bit mask
package hs32_gpio_pkg;

   localparam int unsigned GPIO_SYNC_STAGES = 2;

   // Word offsets (byte offset >> 2).
   localparam logic [5:0] GPIO_OFF_OUT  = 6'h00;  // 0x00
   localparam logic [5:0] GPIO_OFF_OEB  = 6'h01;  // 0x04
   localparam logic [5:0] GPIO_OFF_IN   = 6'h02;  // 0x08
   localparam logic [5:0] GPIO_OFF_IEN  = 6'h03;  // 0x0C
   localparam logic [5:0] GPIO_OFF_EDGE = 6'h04;  // 0x10
   localparam logic [5:0] GPIO_OFF_PEND = 6'h05;  // 0x14
   localparam logic [5:0] GPIO_OFF_SET  = 6'h06;  // 0x18
   localparam logic [5:0] GPIO_OFF_CLR  = 6'h07;  // 0x1C
   localparam logic [5:0] GPIO_OFF_TGL  = 6'h08;  // 0x20

   function automatic logic [31:0] gpio_byte_mask(input logic [3:0] sel);
      logic [31:0] m;
      m = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         m[i*8 +: 8] = {8{sel[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/hs32_sync_edge.sv
// hs32_sync_edge
//   One GPIO channel input path: GPIO_SYNC_STAGES-flop synchroniser followed
//   by one history flop for edge detection.
//   Ports:
//     i_clk  : clock
//     i_rst  : asynchronous active-high reset
//     i_pad  : raw pad input (asynchronous)
//     o_sync : synchronised pad level
//     o_rise : synchronised level just went 0->1 (one-cycle pulse)
//     o_fall : synchronised level just went 1->0 (one-cycle pulse)
module hs32_sync_edge
   import hs32_gpio_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_pad,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic [GPIO_SYNC_STAGES-1:0] r_sync;
   logic                        r_prev;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[GPIO_SYNC_STAGES-2:0], i_pad};
         r_prev <= r_sync[GPIO_SYNC_STAGES-1];
      end
   end

   assign o_sync = r_sync[GPIO_SYNC_STAGES-1];
   assign o_rise =  r_sync[GPIO_SYNC_STAGES-1] & ~r_prev;
   assign o_fall = ~r_sync[GPIO_SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/hs32_wb_gpio.sv
// hs32_wb_gpio
//   Wishbone-slave GPIO bank with OUT/OEB/IN/IEN/EDGE/PEND registers and a
//   registered level interrupt.
//   Optional: define HS32_GPIO_ATOMIC_EN to add OUT_SET/OUT_CLR/OUT_TGL
//   write-only aliases at 0x18/0x1C/0x20; otherwise those offsets are unmapped.
//   Ports:
//     wb_clk_i, wb_rst_i      : clock, asynchronous active-high reset
//     wbs_*                   : Wishbone slave (cyc/stb/we/sel/dat/adr/ack)
//     gpio_in                 : pad inputs (asynchronous)
//     gpio_out, gpio_oeb      : pad output value and output-enable-bar
//     irq_o                   : |(PEND & IEN), registered
module hs32_wb_gpio
   import hs32_gpio_pkg::*;
#(
   parameter int unsigned      NPINS     = 32,
   parameter logic [31:0]      BASE_ADDR = 32'h3000_0000,
   parameter logic [NPINS-1:0] OEB_RST   = {NPINS{1'b1}}
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_dat_i,
   input  logic [31:0]      wbs_adr_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic [NPINS-1:0] gpio_in,
   output logic [NPINS-1:0] gpio_out,
   output logic [NPINS-1:0] gpio_oeb,
   output logic             irq_o
);

   logic             r_ack;
   logic [31:0]      r_dat;
   logic [NPINS-1:0] r_out, r_oeb, r_ien, r_edge, r_pend;
   logic             r_irq;

   logic             w_hit, w_acc, w_wr;
   logic [5:0]       w_off;
   logic [31:0]      w_mask;
   logic [NPINS-1:0] w_wmask, w_wdat;
   logic [NPINS-1:0] w_sync, w_rise, w_fall, w_evt;
   logic [NPINS-1:0] w_out_nxt, w_oeb_nxt, w_ien_nxt, w_edge_nxt, w_w1c;
   logic [31:0]      w_rdat;
   logic             w_unused;

   assign w_unused = ^wbs_adr_i[1:0];

   assign w_hit   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   // A hit while ack is high is the tail of the previous access, not a new one.
   assign w_acc   = w_hit & ~r_ack;
   assign w_wr    = w_acc & wbs_we_i;
   assign w_off   = wbs_adr_i[7:2];
   assign w_mask  = gpio_byte_mask(wbs_sel_i);
   assign w_wmask = w_mask[NPINS-1:0];
   assign w_wdat  = wbs_dat_i[NPINS-1:0] & w_wmask;

   for (genvar g = 0; g < NPINS; g++) begin : g_ch
      hs32_sync_edge u_sync_edge (
         .i_clk  (wb_clk_i),
         .i_rst  (wb_rst_i),
         .i_pad  (gpio_in[g]),
         .o_sync (w_sync[g]),
         .o_rise (w_rise[g]),
         .o_fall (w_fall[g])
      );
   end

   assign w_evt = (r_edge & w_rise) | (~r_edge & w_fall);

   always_comb begin
      w_out_nxt  = r_out;
      w_oeb_nxt  = r_oeb;
      w_ien_nxt  = r_ien;
      w_edge_nxt = r_edge;
      w_w1c      = '0;
      if (w_wr) begin
         case (w_off)
            GPIO_OFF_OUT:  w_out_nxt  = (r_out  & ~w_wmask) | w_wdat;
            GPIO_OFF_OEB:  w_oeb_nxt  = (r_oeb  & ~w_wmask) | w_wdat;
            GPIO_OFF_IEN:  w_ien_nxt  = (r_ien  & ~w_wmask) | w_wdat;
            GPIO_OFF_EDGE: w_edge_nxt = (r_edge & ~w_wmask) | w_wdat;
            GPIO_OFF_PEND: w_w1c      = w_wdat;
`ifdef HS32_GPIO_ATOMIC_EN
            GPIO_OFF_SET:  w_out_nxt  = r_out | w_wdat;
            GPIO_OFF_CLR:  w_out_nxt  = r_out & ~w_wdat;
            GPIO_OFF_TGL:  w_out_nxt  = r_out ^ w_wdat;
`endif
            default: ;
         endcase
      end
   end

   always_comb begin
      w_rdat = '0;
      case (w_off)
         GPIO_OFF_OUT:  w_rdat[NPINS-1:0] = r_out;
         GPIO_OFF_OEB:  w_rdat[NPINS-1:0] = r_oeb;
         GPIO_OFF_IN:   w_rdat[NPINS-1:0] = w_sync;
         GPIO_OFF_IEN:  w_rdat[NPINS-1:0] = r_ien;
         GPIO_OFF_EDGE: w_rdat[NPINS-1:0] = r_edge;
         GPIO_OFF_PEND: w_rdat[NPINS-1:0] = r_pend;
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack  <= 1'b0;
         r_dat  <= '0;
         r_out  <= '0;
         r_oeb  <= OEB_RST;
         r_ien  <= '0;
         r_edge <= '0;
         r_pend <= '0;
         r_irq  <= 1'b0;
      end else begin
         r_ack  <= w_acc;
         r_dat  <= (w_acc & ~wbs_we_i) ? w_rdat : '0;
         r_out  <= w_out_nxt;
         r_oeb  <= w_oeb_nxt;
         r_ien  <= w_ien_nxt;
         r_edge <= w_edge_nxt;
         // New edge is OR-ed in after the clear so it survives a same-cycle W1C.
         r_pend <= (r_pend & ~w_w1c) | w_evt;
         r_irq  <= |(r_pend & r_ien);
      end
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign gpio_out  = r_out;
   assign gpio_oeb  = r_oeb;
   assign irq_o     = r_irq;

endmodule

// File: tb/tb_hs32_wb_gpio.sv
module tb_hs32_wb_gpio;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stb, cyc, we;
   logic [3:0]  sel;
   logic [31:0] dat_i, adr;
   logic        ack;
   logic [31:0] dat_o;
   logic [31:0] gin, gout, goeb;
   logic        irq;

   always #5 clk = ~clk;

   hs32_wb_gpio #(
      .NPINS     (32),
      .BASE_ADDR (BASE),
      .OEB_RST   (32'hFFFF_FFFF)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_dat_i (dat_i),
      .wbs_adr_i (adr),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_o),
      .gpio_in   (gin),
      .gpio_out  (gout),
      .gpio_oeb  (goeb),
      .irq_o     (irq)
   );

   typedef struct {
      logic [31:0] d;
      bit          chk;
      string       nm;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   // Scoreboard monitor: every ack consumes one expectation.
   always @(negedge clk) begin
      if (ack === 1'b1) begin
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ack: got ack=1 want ack=0");
         end else begin
            exp_t e;
            e = q.pop_front();
            if (e.chk) check(e.nm, dat_o, e.d);
         end
      end
   end

   task automatic wb(input bit w, input logic [7:0] off, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] exp, input string nm);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w;
      adr = BASE | {24'h0, off};
      sel = s; dat_i = d;
      q.push_back('{d: exp, chk: !w, nm: nm});
      @(posedge clk); #1;
      check({nm, "_ack"}, {31'h0, ack}, 32'd1);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      check({nm, "_ackdrop"}, {31'h0, ack}, 32'd0);
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s, input string nm);
      wb(1'b1, off, d, s, 32'h0, nm);
   endtask

   task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string nm);
      wb(1'b0, off, 32'h0, 4'hF, exp, nm);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
      sel = 4'h0; dat_i = '0; adr = '0; gin = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_oeb", goeb, 32'hFFFF_FFFF);
      check("rst_out", gout, 32'h0);
      check("rst_ack", {31'h0, ack}, 32'h0);
      check("rst_dat", dat_o, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      wr(8'h00, 32'h1234_5678, 4'hF, "wr_out0");
      check("out0", gout, 32'h1234_5678);
      wr(8'h04, 32'h0000_0000, 4'hF, "wr_oeb0");
      check("oeb0", goeb, 32'h0);

      // Asynchronous reset while ack is high.
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'hF; dat_i = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      check("mid_ack_hi", {31'h0, ack}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("mid_ack_lo", {31'h0, ack}, 32'd0);
      check("mid_oeb", goeb, 32'hFFFF_FFFF);
      check("mid_out", gout, 32'h0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Byte-selected OUT writes.
      wr(8'h00, 32'hA5A5_5A5A, 4'b0011, "wr_out_lo");
      check("out_lo", gout, 32'h0000_5A5A);
      rd(8'h00, 32'h0000_5A5A, "rd_out_lo");
      wr(8'h00, 32'hFFFF_0000, 4'b1100, "wr_out_hi");
      check("out_hi", gout, 32'hFFFF_5A5A);
      rd(8'h00, 32'hFFFF_5A5A, "rd_out_hi");
      wr(8'h04, 32'h0000_FFFF, 4'hF, "wr_oeb");
      check("oeb", goeb, 32'h0000_FFFF);
      rd(8'h04, 32'h0000_FFFF, "rd_oeb");

      // Rising edge on pin 3 with interrupt enabled.
      wr(8'h10, 32'h0000_0008, 4'hF, "wr_edge");
      wr(8'h0C, 32'h0000_0008, 4'hF, "wr_ien");
      rd(8'h10, 32'h0000_0008, "rd_edge");
      @(negedge clk);
      gin[3] = 1'b1;
      repeat (2) @(posedge clk);
      rd(8'h08, 32'h0000_0008, "rd_in3");
      rd(8'h14, 32'h0000_0008, "rd_pend3");
      check("irq_set", {31'h0, irq}, 32'd1);
      wr(8'h14, 32'h0000_0008, 4'hF, "w1c_pend3");
      check("irq_clr", {31'h0, irq}, 32'd0);
      rd(8'h14, 32'h0000_0000, "rd_pend3_clr");

      // Falling edges on pin 5 (EDGE[5]=0, IEN[5]=0); pin 3 fall is not selected.
      @(negedge clk);
      gin[5] = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      gin[5] = 1'b0;
      gin[3] = 1'b0;
      repeat (4) @(posedge clk);
      rd(8'h14, 32'h0000_0020, "rd_pend5");
      check("irq_masked", {31'h0, irq}, 32'd0);
      @(negedge clk);
      gin[5] = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      gin[5] = 1'b0;
      // W1C commits on the edge where the fall is being detected.
      repeat (2) @(posedge clk);
      wr(8'h14, 32'h0000_0020, 4'hF, "w1c_race");
      rd(8'h14, 32'h0000_0020, "rd_pend5_race");
      wr(8'h14, 32'h0000_0020, 4'hF, "w1c_pend5");
      rd(8'h14, 32'h0000_0000, "rd_pend5_clr");
      rd(8'h08, 32'h0000_0000, "rd_in0");

      // Unmapped offset and out-of-window address.
      rd(8'h3C, 32'h0, "rd_unmapped");
      wr(8'h3C, 32'hDEAD_BEEF, 4'hF, "wr_unmapped");
      rd(8'h00, 32'hFFFF_5A5A, "rd_out_after_unmapped");
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100; sel = 4'hF;
      @(posedge clk); #1;
      check("noack_1", {31'h0, ack}, 32'd0);
      @(posedge clk); #1;
      check("noack_2", {31'h0, ack}, 32'd0);
      cyc = 1'b0; stb = 1'b0;

`ifdef HS32_GPIO_ATOMIC_EN
      wr(8'h00, 32'h0000_00F0, 4'hF, "wr_out_f0");
      wr(8'h20, 32'h0000_00FF, 4'hF, "wr_tgl");
      rd(8'h00, 32'h0000_000F, "rd_tgl");
      wr(8'h18, 32'h0000_0100, 4'hF, "wr_set");
      rd(8'h00, 32'h0000_010F, "rd_set");
      check("out_set", gout, 32'h0000_010F);
      wr(8'h1C, 32'h0000_0301, 4'b0001, "wr_clr");
      rd(8'h00, 32'h0000_010E, "rd_clr");
      rd(8'h20, 32'h0, "rd_tgl_reg");
`else
      wr(8'h00, 32'h0000_00F0, 4'hF, "wr_out_f0");
      wr(8'h18, 32'h0000_0100, 4'hF, "wr_set_unmapped");
      rd(8'h00, 32'h0000_00F0, "rd_out_noset");
      rd(8'h18, 32'h0, "rd_set_unmapped");
`endif

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
